// File: rtl/gray_bin_conv_pipe.sv
// Registered Gray<->binary converter with valid/ready handshake, per-word mode
// select and an optional Gray-adjacency checker with a saturating error counter.
module gray_bin_conv_pipe #(
    parameter int WIDTH     = 8,
    parameter bit CHECK_ADJ = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_adj_err,
    input  logic             clr_err,
    output logic [7:0]       err_cnt
);

    logic [WIDTH-1:0] g2b;
    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] cur_gray;
    logic             accept;
    logic             adj_err_next;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_conv
            assign g2b[gi] = ^in_data[WIDTH-1:gi];
            if (gi == WIDTH - 1) begin : g_msb
                assign b2g[gi] = in_data[gi];
            end else begin : g_lsb
                assign b2g[gi] = in_data[gi] ^ in_data[gi+1];
            end
        end
    endgenerate

    assign conv     = in_mode ? b2g : g2b;
    assign cur_gray = in_mode ? b2g : in_data;

    generate
        if (CHECK_ADJ) begin : g_adj
            localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
            logic [WIDTH-1:0] prev_gray_reg;
            logic             have_prev_reg;
            logic [7:0]       err_cnt_reg;
            logic [WIDTH-1:0] diff;
            logic             one_bit;

            assign diff         = cur_gray ^ prev_gray_reg;
            // Exactly one bit set: non-zero and a power of two.
            assign one_bit      = (diff != '0) && ((diff & (diff - ONE)) == '0);
            assign adj_err_next = have_prev_reg & ~one_bit;
            assign err_cnt      = err_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_gray_reg <= '0;
                    have_prev_reg <= 1'b0;
                    err_cnt_reg   <= 8'd0;
                end else begin
                    if (accept) begin
                        prev_gray_reg <= cur_gray;
                        have_prev_reg <= 1'b1;
                    end
                    if (clr_err) begin
                        err_cnt_reg <= 8'd0;
                    end else if (accept && adj_err_next && err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                    end
                end
            end
        end else begin : g_no_adj
            assign adj_err_next = 1'b0;
            assign err_cnt      = 8'd0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_mode    <= 1'b0;
            out_adj_err <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_data    <= conv;
            out_mode    <= in_mode;
            out_adj_err <= adj_err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
